// File: rtl/rs_issue_scheduler_pkg.sv
// Shared types and constants for the reservation-station issue scheduler.
package rs_issue_scheduler_pkg;

  // Functional-unit class carried by each RS row.
  typedef enum logic [1:0] {
    FuAlu   = 2'd0,
    FuMult  = 2'd1,
    FuLoad  = 2'd2,
    FuStore = 2'd3
  } FU_TYPE_T;

  localparam int unsigned NUM_FU = 4;

  // Slot positions within slot_valid / slot_idx.
  localparam int unsigned SLOT_ALU0 = 0;
  localparam int unsigned SLOT_ALU1 = 1;
  localparam int unsigned SLOT_MULT = 2;
  localparam int unsigned SLOT_MEM  = 3;

  // Number of set bits in a 4-bit grant vector.
  function automatic logic [2:0] popcount4(input logic [3:0] v);
    return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
  endfunction

endpackage

// File: rtl/rs_prio_enc.sv
// Lowest-index priority encoder: reports whether any request bit is set and
// the index of the lowest one (oldest RS row).
module rs_prio_enc #(
  parameter int unsigned Width = 16,
  parameter int unsigned IdxW  = (Width > 1) ? $clog2(Width) : 1
) (
  input  logic [Width-1:0] req_i,
  output logic             valid_o,
  output logic [IdxW-1:0]  idx_o
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    for (int i = Width - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        valid_o = 1'b1;
        idx_o   = IdxW'(i);
      end
    end
  end

endmodule

// File: rtl/rs_issue_scheduler.sv
// Per-cycle issue scheduler: binds up to four ready RS rows to the ALU0, ALU1,
// MULT and MEM slots, tracks multiplier occupancy and registers slot grants.
module rs_issue_scheduler
  import rs_issue_scheduler_pkg::*;
#(
  parameter int unsigned RS_SIZE  = 16,
  parameter int unsigned MULT_LAT = 4,
  localparam int unsigned IDX_W   = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1,
  localparam int unsigned CNT_W   = $clog2(MULT_LAT) + 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [RS_SIZE-1:0]      row_ready,
  input  logic [2*RS_SIZE-1:0]    row_fu_type,
  input  logic [1:0]              LSQ_busy,
  input  logic                    ex_stall,
  input  logic                    squash,
  output logic [RS_SIZE-1:0]      issue_code,
  output logic [2:0]              issue_cnt,
  output logic [NUM_FU-1:0]       slot_valid,
  output logic [NUM_FU*IDX_W-1:0] slot_idx,
  output logic                    mult_busy
);

  logic [RS_SIZE-1:0] alu_mask, alu1_mask, mult_mask, mem_mask, alu0_onehot;
  logic [NUM_FU-1:0]  pick_valid, grant;
  logic [IDX_W-1:0]   pick_idx [NUM_FU];
  logic               grant_en;

  logic [CNT_W-1:0]        mult_cnt_q, mult_cnt_d;
  logic                    mult_busy_q, mult_busy_d;
  logic [NUM_FU-1:0]       slot_valid_q, slot_valid_d;
  logic [NUM_FU*IDX_W-1:0] slot_idx_q, slot_idx_d;

  // Per-class eligibility masks.
  always_comb begin
    FU_TYPE_T ty;
    ty        = FuAlu;
    alu_mask  = '0;
    mult_mask = '0;
    mem_mask  = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      ty           = FU_TYPE_T'(row_fu_type[2*i +: 2]);
      alu_mask[i]  = row_ready[i] && (ty == FuAlu);
      mult_mask[i] = row_ready[i] && (ty == FuMult) && (mult_cnt_q == '0);
      mem_mask[i]  = row_ready[i] && (((ty == FuLoad) && !LSQ_busy[0]) ||
                                      ((ty == FuStore) && !LSQ_busy[1]));
    end
  end

  rs_prio_enc #(.Width(RS_SIZE), .IdxW(IDX_W)) u_enc_alu0 (
    .req_i   (alu_mask),
    .valid_o (pick_valid[SLOT_ALU0]),
    .idx_o   (pick_idx[SLOT_ALU0])
  );

  rs_prio_enc #(.Width(RS_SIZE), .IdxW(IDX_W)) u_enc_alu1 (
    .req_i   (alu1_mask),
    .valid_o (pick_valid[SLOT_ALU1]),
    .idx_o   (pick_idx[SLOT_ALU1])
  );

  rs_prio_enc #(.Width(RS_SIZE), .IdxW(IDX_W)) u_enc_mult (
    .req_i   (mult_mask),
    .valid_o (pick_valid[SLOT_MULT]),
    .idx_o   (pick_idx[SLOT_MULT])
  );

  rs_prio_enc #(.Width(RS_SIZE), .IdxW(IDX_W)) u_enc_mem (
    .req_i   (mem_mask),
    .valid_o (pick_valid[SLOT_MEM]),
    .idx_o   (pick_idx[SLOT_MEM])
  );

  // ALU1 sees the ALU mask with ALU0's pick removed; gate all grants.
  always_comb begin
    alu0_onehot = pick_valid[SLOT_ALU0] ? (RS_SIZE'(1) << pick_idx[SLOT_ALU0]) : '0;
    alu1_mask   = alu_mask & ~alu0_onehot;
    grant_en    = reset && !ex_stall && !squash;
    grant       = grant_en ? pick_valid : '0;
  end

  // Same-cycle grant vector and count for RS compaction.
  always_comb begin
    issue_code = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      if (grant[k]) begin
        issue_code = issue_code | (RS_SIZE'(1) << pick_idx[k]);
      end
    end
    issue_cnt = popcount4(grant);
  end

  // Multiplier occupancy counter; keeps counting even under ex_stall.
  always_comb begin
    mult_cnt_d = mult_cnt_q;
    if (squash) begin
      mult_cnt_d = '0;
    end else if (grant[SLOT_MULT]) begin
      mult_cnt_d = CNT_W'(MULT_LAT - 1);
    end else if (mult_cnt_q != '0) begin
      mult_cnt_d = mult_cnt_q - 1'b1;
    end
    mult_busy_d = (mult_cnt_d != '0);
  end

  // Slot register next state: squash clears, ex_stall holds, otherwise load.
  always_comb begin
    slot_valid_d = slot_valid_q;
    slot_idx_d   = slot_idx_q;
    if (squash) begin
      slot_valid_d = '0;
      slot_idx_d   = '0;
    end else if (!ex_stall) begin
      slot_valid_d = grant;
      for (int k = 0; k < NUM_FU; k++) begin
        slot_idx_d[k*IDX_W +: IDX_W] = grant[k] ? pick_idx[k] : '0;
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mult_cnt_q   <= '0;
      mult_busy_q  <= 1'b0;
      slot_valid_q <= '0;
      slot_idx_q   <= '0;
    end else begin
      mult_cnt_q   <= mult_cnt_d;
      mult_busy_q  <= mult_busy_d;
      slot_valid_q <= slot_valid_d;
      slot_idx_q   <= slot_idx_d;
    end
  end

  assign slot_valid = slot_valid_q;
  assign slot_idx   = slot_idx_q;
  assign mult_busy  = mult_busy_q;

endmodule

// File: tb/tb_rs_issue_scheduler.sv
// Directed bench for rs_issue_scheduler with a slot-output scoreboard.
module tb_rs_issue_scheduler;

  logic        clk;
  logic        reset;
  logic [15:0] row_ready;
  logic [31:0] row_fu_type;
  logic [1:0]  LSQ_busy;
  logic        ex_stall;
  logic        squash;
  logic [15:0] issue_code;
  logic [2:0]  issue_cnt;
  logic [3:0]  slot_valid;
  logic [15:0] slot_idx;
  logic        mult_busy;

  typedef struct packed {
    logic [3:0]  v;
    logic [15:0] idx;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  rs_issue_scheduler #(.RS_SIZE(16), .MULT_LAT(4)) dut (
    .clock       (clk),
    .reset       (reset),
    .row_ready   (row_ready),
    .row_fu_type (row_fu_type),
    .LSQ_busy    (LSQ_busy),
    .ex_stall    (ex_stall),
    .squash      (squash),
    .issue_code  (issue_code),
    .issue_cnt   (issue_cnt),
    .slot_valid  (slot_valid),
    .slot_idx    (slot_idx),
    .mult_busy   (mult_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_comb(input string tag, input logic [15:0] code, input logic [2:0] cnt);
    check({tag, "_code"}, 32'(issue_code), 32'(code));
    check({tag, "_cnt"}, 32'(issue_cnt), 32'(cnt));
  endtask

  task automatic expect_slots(input logic [3:0] v, input logic [15:0] idx);
    exp_t e;
    e.v   = v;
    e.idx = idx;
    exp_q.push_back(e);
  endtask

  // Advance one cycle and score the registered slot outputs.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("slot_valid", 32'(slot_valid), 32'(e.v));
      check("slot_idx", 32'(slot_idx), 32'(e.idx));
    end
  endtask

  function automatic logic [31:0] with_type(input logic [31:0] f, input int row,
                                            input logic [1:0] t);
    logic [31:0] r;
    r            = f;
    r[2*row +: 2] = t;
    return r;
  endfunction

  initial begin
    reset       = 1'b0;
    row_ready   = 16'hFFFF;
    row_fu_type = 32'hE4E4_E4E4;
    LSQ_busy    = 2'b00;
    ex_stall    = 1'b0;
    squash      = 1'b0;

    // Reset state: everything quiet even with all rows ready.
    #3;
    check_comb("in_reset", 16'h0000, 3'd0);
    check("rst_slot_valid", 32'(slot_valid), 32'h0);
    check("rst_slot_idx", 32'(slot_idx), 32'h0);
    check("rst_mult_busy", 32'(mult_busy), 32'h0);

    @(posedge clk);
    #1;
    reset = 1'b1;

    // Mixed ALU/MULT/LOAD pattern: ALUs 0,3 win over 5; MULT 7; MEM 9.
    row_ready   = 16'h02A9;
    row_fu_type = with_type(with_type(32'h0, 7, 2'd1), 9, 2'd2);
    #1;
    check_comb("mixed", 16'h0289, 3'd4);
    expect_slots(4'b1111, 16'h9730);
    tick();

    // Multiplier occupied for three cycles, second MULT row waits.
    row_ready   = 16'h0080;
    row_fu_type = with_type(32'h0, 7, 2'd1);
    for (int k = 1; k <= 3; k++) begin
      #1;
      check("mult_busy_occ", 32'(mult_busy), 32'h1);
      check_comb("mult_wait", 16'h0000, 3'd0);
      expect_slots(4'b0000, 16'h0000);
      tick();
    end
    check("mult_busy_free", 32'(mult_busy), 32'h0);
    check_comb("mult_reissue", 16'h0080, 3'd1);
    expect_slots(4'b0100, 16'h0700);
    tick();
    check("mult_busy_again", 32'(mult_busy), 32'h1);

    // ex_stall: no grants, slots hold, multiplier counts down.
    ex_stall    = 1'b1;
    row_ready   = 16'h0002;
    row_fu_type = 32'h0;
    #1;
    check_comb("stall", 16'h0000, 3'd0);
    expect_slots(4'b0100, 16'h0700);
    tick();
    check("stall_busy1", 32'(mult_busy), 32'h1);
    expect_slots(4'b0100, 16'h0700);
    tick();
    check("stall_busy2", 32'(mult_busy), 32'h1);
    expect_slots(4'b0100, 16'h0700);
    tick();
    check("stall_busy3", 32'(mult_busy), 32'h0);

    // Grant a MULT, then squash during stall while busy.
    ex_stall    = 1'b0;
    row_ready   = 16'h0008;
    row_fu_type = with_type(32'h0, 3, 2'd1);
    #1;
    check_comb("mult_row3", 16'h0008, 3'd1);
    expect_slots(4'b0100, 16'h0300);
    tick();
    check("pre_squash_busy", 32'(mult_busy), 32'h1);
    ex_stall  = 1'b1;
    squash    = 1'b1;
    row_ready = 16'h0009;
    #1;
    check_comb("squash", 16'h0000, 3'd0);
    expect_slots(4'b0000, 16'h0000);
    tick();
    check("squash_busy", 32'(mult_busy), 32'h0);
    ex_stall = 1'b0;
    squash   = 1'b0;
    #1;
    check_comb("post_squash", 16'h0009, 3'd2);
    expect_slots(4'b0101, 16'h0300);
    tick();

    // LSQ back-pressure takes effect in the same cycle.
    row_ready   = 16'h0014;
    row_fu_type = with_type(with_type(32'h0, 2, 2'd2), 4, 2'd3);
    LSQ_busy    = 2'b01;
    #1;
    check_comb("lsq_load_blk", 16'h0010, 3'd1);
    LSQ_busy = 2'b10;
    #1;
    check_comb("lsq_store_blk", 16'h0004, 3'd1);
    expect_slots(4'b1000, 16'h2000);
    tick();
    LSQ_busy = 2'b11;
    #1;
    check_comb("lsq_both_blk", 16'h0000, 3'd0);
    expect_slots(4'b0000, 16'h0000);
    tick();
    LSQ_busy = 2'b00;

    // Idle: slots clear, multiplier drains.
    row_ready = 16'h0000;
    #1;
    check_comb("empty", 16'h0000, 3'd0);
    expect_slots(4'b0000, 16'h0000);
    tick();
    check("drained_busy", 32'(mult_busy), 32'h0);

    // All 16 rows ready with rotating classes: at most four grants.
    row_ready   = 16'hFFFF;
    row_fu_type = 32'hE4E4_E4E4;
    #1;
    check_comb("full", 16'h0017, 3'd4);
    expect_slots(4'b1111, 16'h2140);
    tick();

    // Asynchronous reset mid-cycle clears outputs without a clock edge.
    #3;
    reset = 1'b0;
    #1;
    check("arst_slot_valid", 32'(slot_valid), 32'h0);
    check("arst_slot_idx", 32'(slot_idx), 32'h0);
    check("arst_mult_busy", 32'(mult_busy), 32'h0);
    check_comb("arst", 16'h0000, 3'd0);
    @(posedge clk);
    #1;
    check("held_in_reset", 32'(slot_valid), 32'h0);
    reset = 1'b1;
    #1;
    check_comb("after_release", 16'h0017, 3'd4);
    expect_slots(4'b1111, 16'h2140);
    tick();

    row_ready = 16'h0000;
    #1;
    check_comb("final_empty", 16'h0000, 3'd0);
    expect_slots(4'b0000, 16'h0000);
    tick();

    check("sb_drained", 32'(exp_q.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rs_issue_scheduler.md
# rs_issue_scheduler

Per-cycle issue scheduler for the reservation station. Each cycle it takes the ready/type vector of the RS rows, chooses up to four rows, and binds each to a functional-unit slot: ALU0, ALU1, MULT or MEM. It tracks occupancy of the non-pipelined multiplier and honours LSQ back-pressure. It drives the same-cycle `issue_code`/`issue_cnt` used by the RS compaction logic and registers the per-slot grants toward the issue/execute pipeline register.

## Interface
- `RS_SIZE`, 16, number of RS rows; row 0 is the oldest (RS compacts toward index 0).
- `MULT_LAT`, 4, cycles the multiplier stays occupied per grant; must be ≥1.
- `clock`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low reset.
- `row_ready`  in  RS_SIZE  row valid and both source tags ready.
- `row_fu_type`  in  RS_SIZE×2  FU class per row: 0 ALU, 1 MULT, 2 LOAD, 3 STORE.
- `LSQ_busy`  in  2  bit0 blocks LOAD issue, bit1 blocks STORE issue.
- `ex_stall`  in  1  execute stage cannot accept; suppresses all grants.
- `squash`  in  1  branch mispredict flush.
- `issue_code`  out  RS_SIZE  combinational; rows granted this cycle.
- `issue_cnt`  out  3  combinational; popcount of `issue_code` (0..4).
- `slot_valid`  out  4  registered; slot order {MEM, MULT, ALU1, ALU0}.
- `slot_idx`  out  4×$clog2(RS_SIZE)  registered RS row index per slot.
- `mult_busy`  out  1  registered; multiplier occupied.

## Operation
- Eligibility per row: `row_ready` is set and:
  - ALU rows are always eligible.
  - MULT rows are eligible only when `mult_cnt`==0.
  - LOAD rows require `LSQ_busy[0]`==0; STORE rows require `LSQ_busy[1]`==0.
- Selection is oldest-first (lowest index) within each class:
  - ALU0 takes the lowest eligible ALU row; ALU1 takes the next-lowest.
  - MULT takes the lowest eligible MULT row.
  - MEM takes the lowest eligible LOAD or STORE row.
- A row is granted at most once. Classes are disjoint, so there are no cross-slot conflicts.
- Grants are forced to zero when `ex_stall`, `squash`, or `reset` is asserted. In that case `issue_code`=0 and `issue_cnt`=0.
- `mult_cnt` (width $clog2(MULT_LAT)+1):
  - On a MULT grant it loads MULT_LAT-1.
  - Otherwise it decrements while nonzero.
  - `squash` clears it to 0.
- `mult_busy` = (next `mult_cnt` != 0), registered.
- Registered slot outputs:
  - On a cycle with no stall: `slot_valid`/`slot_idx` load this cycle's grants.
  - Under `ex_stall`: they hold their previous values.
  - Under `squash`: `slot_valid` clears to 0; `squash` has priority over `ex_stall`.
- `slot_idx` is don't-care when the matching `slot_valid` is 0, but is driven to 0 in that case for determinism.

## Timing
- Reset values (asynchronous, on `reset` low): `slot_valid`=0, `slot_idx`=0, `mult_cnt`=0, `mult_busy`=0.
- Combinational outputs are 0 while `reset` is low.
- Release of `reset` takes effect at the next `clock` edge; a grant is possible in the first cycle after release.
- `issue_code` and `issue_cnt` are valid in the same cycle as `row_ready`. The RS uses them at its next edge.
- Slot outputs appear one cycle after the grant (latency 1).
- Multiplier occupancy:
  - A MULT grant at cycle t makes MULT eligible again at cycle t+MULT_LAT.
  - With MULT_LAT=1, MULT grants can issue back-to-back.
- Simultaneous events:
  - `squash` together with a MULT grant request: no grant, and the counter is 0 next cycle.
  - `ex_stall` does not freeze `mult_cnt`; the multiplier keeps counting down.
  - `LSQ_busy` changes take effect the same cycle; there is no registered LSQ state.
- Full and empty cases:
  - All 16 rows ready: `issue_cnt`≤4.
  - No rows ready: `issue_cnt`=0 and the slot outputs clear to invalid next cycle.
- Reset asserted mid-operation clears all state immediately; in-flight multiplier occupancy is discarded.

## Structure
- The shared package holds:
  - the `FU_TYPE_T` enum (ALU, MULT, LOAD, STORE);
  - the slot index constants (SLOT_ALU0=0, SLOT_ALU1=1, SLOT_MULT=2, SLOT_MEM=3);
  - `NUM_FU`=4.
- Sub-module `rs_prio_enc`: a parameterised lowest-index priority encoder over RS_SIZE bits, producing a valid flag and an index.
  - It is instantiated once each for ALU0, MULT and MEM.
  - It is instantiated again for ALU1 on the ALU mask with the ALU0 pick removed.
- The top level contains `mult_cnt` and the slot registers.

## Test plan
- Rows 0, 3 and 5 ready ALU; row 7 ready MULT; row 9 ready LOAD:
  - `issue_code`=0x0289, `issue_cnt`=4;
  - next cycle `slot_idx`={9,7,3,0} and `slot_valid`=4'b1111.
- MULT grant at t with MULT_LAT=4 and a second MULT row ready throughout:
  - `mult_busy`=1 during t+1..t+3;
  - the second grant occurs at t+4.
- `LSQ_busy`=2'b01 with ready LOAD row 2 and STORE row 4: only row 4 is granted to MEM.
- `ex_stall`=1 with ready rows present:
  - `issue_code`=0;
  - `slot_*` hold their values;
  - `mult_cnt` keeps decrementing.
- `squash` pulsed while `mult_busy`=1 and `ex_stall`=1:
  - next cycle `slot_valid`=0 and `mult_busy`=0;
  - a MULT grant is possible the following cycle.
- Assert `reset` low asynchronously mid-cycle with `slot_valid`=4'b1111:
  - outputs clear immediately, before any clock edge;
  - the first grant comes at the first edge after release.
